addrc_state_collector: RTL and testbench
========================================

# addrc_state_collector

Bit-serial receiver for the Keccak state stream emitted by the add-round-constant stage. The stage produces 1 bit per enabled cycle: 25 bits per slice (lane-index order), 64 slices per state. This block reassembles the 1600-bit state into a 64×25 slice array, flags completion, and exposes the stored state two ways: slice-parallel and lane-parallel. It sits at the consuming end of the iota stage and replaces file-based capture in hardware builds.

## Interface
- No parameters. Geometry is fixed: 25 lanes, 64 slices, 1600 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse: clear counters and begin receiving a new state
- pin  input  1  serial state bit
- pin_valid  input  1  pin is valid this cycle; only sampled in RECV
- rd_slice  input  6  slice index for slice_out
- slice_out  output  25  stored slice rd_slice (combinational read)
- rd_lane  input  5  lane index for lane_out, valid range 0..24
- lane_out  output  64  stored lane rd_lane (combinational read)
- busy  output  1  high in RECV
- done  output  1  high in FULL
- slice_cnt  output  7  completed slices of the current state, 0..64

## Operation
- FSM states:
  - IDLE (reset state)
  - RECV
  - FULL
- Transitions:
  - IDLE → RECV on start.
  - RECV → FULL when the 1600th valid bit is accepted.
  - FULL → RECV on start.
  - start in RECV: abort, clear bit and slice counters, stay in RECV. Array contents are not cleared.
- Counters:
  - bit counter 0..24 (5 bits).
  - slice counter 0..64 (7 bits).
  - Both clear on start.
- Accept rule: a bit is accepted only on a cycle with state==RECV && pin_valid && !start.
  - pin_valid in IDLE or FULL is ignored; no counter or array change.
- Slice assembly:
  - The k-th accepted bit of a slice (k = 0..24) goes to slice bit 24−k. The first-received bit is the MSB, matching the transmit-side ordering FileR_out[24−cnt].
  - Bits accumulate in a 25-bit holding register.
  - On the 25th bit, the full slice (holding register plus current bit) is written to array[slice_cnt]. The slice counter then increments and the bit counter wraps to 0.
- Slice/lane mapping:
  - Slice s received s-th (0..63) holds lane bit 63−s. The first slice carries lane MSBs, matching RC[64−line].
  - lane_out[63−s] = array[s][24−rd_lane].
  - rd_lane > 24 returns all zeros.
- Read ports:
  - Purely combinational from the array; readable in any state.
  - Mid-RECV reads return a mix of new and previous-state slices; this is allowed.
- Reset:
  - State=IDLE; counters, holding register and all 64×25 array bits = 0.
  - busy=0, done=0, slice_cnt=0, slice_out=0, lane_out=0.

## Timing
- Latency, accepted bit → visible:
  - A slice-completing bit accepted at edge N appears on slice_out/lane_out and slice_cnt after edge N.
  - Bits 0..23 of an in-progress slice are not visible on the read ports.
- Completion: done rises and busy falls right after the edge accepting the 1600th valid bit.
  - With pin_valid continuously high, this is edge 1600 after the first RECV cycle.
  - start is registered at edge 0, so the first bit is accepted at edge 1.
- Gaps: deasserting pin_valid stalls both counters with no loss. Any gap pattern yields an identical final state.
- start and pin_valid in the same cycle: start wins and the bit is dropped.
- Async reset mid-RECV: all outputs return to reset values immediately, independent of clk. The next state requires a new start.

## Test plan
- **Full stream, no gaps:** send the 1600 bits of a state whose lane L = 64'h0101_0101_0101_0101 × L (mod 2^64) in slice/lane order, pin_valid=1 throughout.
  - done=1 exactly 1600 edges after the first accepted bit; slice_cnt=64.
  - lane_out matches each lane for rd_lane 0..24; rd_lane=25 → 0.
- **Random pin_valid gaps:** same stream with ~40% idle cycles.
  - Final array is identical to the no-gap run.
  - slice_cnt increments only on slice-completing bits.
- **Round-constant check:** all-zero state with lane 12 (slice bit 24−12) XORed with RC 64'h800000000000808A.
  - lane_out for rd_lane=12 is 64'h800000000000808A; all other lanes are 0.
- **Abort:** start pulse after 700 bits, then a full 1600-bit all-ones stream.
  - No done before the 1600th post-restart bit; final state is all ones.
  - slice_cnt=28 just before the abort and 0 after it.
- **Ignored input and restart:** pin_valid=1 with random pin in IDLE and in FULL → no counter or array change. A start in FULL returns to busy=1, done=0, slice_cnt=0.
- **Reset mid-operation:** assert rst low asynchronously mid-cycle at bit 900.
  - busy, done, slice_cnt, slice_out and lane_out read 0 before the next clk edge.
  - State is IDLE after rst deasserts.

Source files
------------

// File: rtl/addrc_state_collector.sv
// Bit-serial Keccak state collector for the iota stage output.
// Reassembles 64 slices of 25 bits; exposes slice- and lane-parallel reads.
module addrc_state_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pin,
  input  logic        pin_valid,
  input  logic [5:0]  rd_slice,
  output logic [24:0] slice_out,
  input  logic [4:0]  rd_lane,
  output logic [63:0] lane_out,
  output logic        busy,
  output logic        done,
  output logic [6:0]  slice_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_FULL
  } state_t;

  state_t      r_state;
  logic [4:0]  r_bit_cnt;
  logic [6:0]  r_slice_cnt;
  logic [24:0] r_hold;
  logic [24:0] r_mem [64];
  logic        r_busy;
  logic        r_done;

  logic        w_acc;
  logic        w_last_bit;
  logic [4:0]  w_hidx;
  logic [4:0]  w_lidx;
  logic [24:0] w_slice;
  logic [63:0] w_lane;

  assign w_acc      = (r_state == S_RECV) && pin_valid && !start;
  assign w_last_bit = (r_bit_cnt == 5'd24);
  assign w_hidx     = 5'd24 - r_bit_cnt;
  assign w_lidx     = 5'd24 - rd_lane;
  // 25th bit lands in slice bit 0 straight from the pin
  assign w_slice    = {r_hold[24:1], pin};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_slice_cnt <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int s = 0; s < 64; s++)
        r_mem[s] <= '0;
    end else if (start) begin
      r_state     <= S_RECV;
      r_bit_cnt   <= '0;
      r_slice_cnt <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else if (w_acc) begin
      if (w_last_bit) begin
        r_mem[r_slice_cnt[5:0]] <= w_slice;
        r_bit_cnt   <= '0;
        r_slice_cnt <= r_slice_cnt + 7'd1;
        if (r_slice_cnt == 7'd63) begin
          r_state <= S_FULL;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        r_hold[w_hidx] <= pin;
        r_bit_cnt      <= r_bit_cnt + 5'd1;
      end
    end
  end

  // First slice received carries the lane MSBs
  always_comb begin
    w_lane = '0;
    if (rd_lane <= 5'd24) begin
      for (int s = 0; s < 64; s++)
        w_lane[63-s] = r_mem[s][w_lidx];
    end
  end

  assign slice_out = r_mem[rd_slice];
  assign lane_out  = w_lane;
  assign busy      = r_busy;
  assign done      = r_done;
  assign slice_cnt = r_slice_cnt;

endmodule

// File: tb/tb_addrc_state_collector.sv
// Bench for addrc_state_collector: scoreboarded slice writes,
// table-driven lane reads and multi-cycle corner sequences.
module tb_addrc_state_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pin;
  logic        pin_valid;
  logic [5:0]  rd_slice;
  logic [24:0] slice_out;
  logic [4:0]  rd_lane;
  logic [63:0] lane_out;
  logic        busy;
  logic        done;
  logic [6:0]  slice_cnt;

  addrc_state_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pin       (pin),
    .pin_valid (pin_valid),
    .rd_slice  (rd_slice),
    .slice_out (slice_out),
    .rd_lane   (rd_lane),
    .lane_out  (lane_out),
    .busy      (busy),
    .done      (done),
    .slice_cnt (slice_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [24:0] val;
  } sb_t;

  typedef struct {
    logic [4:0]  lane;
    logic [63:0] exp;
  } vec_t;

  sb_t         q[$];
  vec_t        tbl[26];
  logic [63:0] lanes[25];
  logic [63:0] mem_lanes[25];
  int          n_run;
  int          n_fail;
  int          m_state;
  int          m_bit;
  int          m_slice;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic stream_bit(input int i);
    int s;
    int k;
    s = i / 25;
    k = i % 25;
    return lanes[k][63-s];
  endfunction

  function automatic logic [24:0] exp_slice(input int s);
    logic [24:0] v;
    for (int b = 0; b < 25; b++)
      v[b] = lanes[24-b][63-s];
    return v;
  endfunction

  task automatic check_model();
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("done", 64'(done), 64'(m_state == 2));
    chk("slice_cnt", 64'(slice_cnt), 64'(m_slice));
  endtask

  task automatic send_bit(input logic p, input logic v);
    logic cmp;
    sb_t  e;
    cmp = 1'b0;
    pin = p;
    pin_valid = v;
    if (m_state == 1 && v) begin
      if (m_bit == 24) begin
        q.push_back('{m_slice, exp_slice(m_slice)});
        cmp = 1'b1;
      end
    end
    @(posedge clk);
    if (m_state == 1 && v) begin
      if (m_bit == 24) begin
        m_bit = 0;
        for (int b = 0; b < 25; b++)
          mem_lanes[b][63-m_slice] = lanes[b][63-m_slice];
        m_slice++;
        if (m_slice == 64) m_state = 2;
      end else begin
        m_bit++;
      end
    end
    #1;
    pin_valid = 1'b0;
    check_model();
    if (cmp) begin
      e = q.pop_front();
      rd_slice = 6'(e.idx);
      #1;
      chk($sformatf("slice_out[%0d]", e.idx), 64'(slice_out), 64'(e.val));
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    pin_valid = 1'b1;
    pin = 1'b1;
    @(posedge clk);
    m_state = 1;
    m_bit = 0;
    m_slice = 0;
    #1;
    start = 1'b0;
    pin_valid = 1'b0;
    check_model();
  endtask

  task automatic send_state(input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps)
        while ($urandom_range(0, 9) < 4)
          send_bit(1'($urandom_range(0, 1)), 1'b0);
      send_bit(stream_bit(i), 1'b1);
    end
  endtask

  task automatic check_lanes(input string nm);
    for (int i = 0; i < 26; i++)
      tbl[i] = '{5'(i), (i < 25) ? mem_lanes[i] : 64'h0};
    for (int i = 0; i < 26; i++) begin
      rd_lane = tbl[i].lane;
      #1;
      chk($sformatf("%s lane %0d", nm, i), lane_out, tbl[i].exp);
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    m_state = 0;
    m_bit = 0;
    m_slice = 0;
    rst = 1'b0;
    start = 1'b0;
    pin = 1'b0;
    pin_valid = 1'b0;
    rd_slice = '0;
    rd_lane = '0;
    for (int l = 0; l < 25; l++) mem_lanes[l] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    check_model();
    chk("reset slice_out", 64'(slice_out), 64'h0);
    chk("reset lane_out", lane_out, 64'h0);

    for (int l = 0; l < 25; l++)
      lanes[l] = 64'h0101_0101_0101_0101 * 64'(l);
    for (int i = 0; i < 30; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b1);
    check_lanes("idle");

    do_start();
    send_state(1600, 1'b0);
    check_lanes("nogap");

    for (int i = 0; i < 40; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b1);
    check_lanes("full_ign");

    do_start();
    chk("restart busy", 64'(busy), 64'h1);
    chk("restart done", 64'(done), 64'h0);
    chk("restart cnt", 64'(slice_cnt), 64'h0);
    for (int l = 0; l < 25; l++) mem_lanes[l] = '0;
    send_state(1600, 1'b1);
    check_lanes("gaps");

    for (int l = 0; l < 25; l++) lanes[l] = '0;
    lanes[12] = 64'h8000_0000_0000_808A;
    do_start();
    send_state(1600, 1'b0);
    check_lanes("rc");

    for (int l = 0; l < 25; l++)
      lanes[l] = 64'h0101_0101_0101_0101 * 64'(l);
    do_start();
    send_state(700, 1'b0);
    chk("abort pre cnt", 64'(slice_cnt), 64'd28);
    do_start();
    chk("abort post cnt", 64'(slice_cnt), 64'd0);
    for (int l = 0; l < 25; l++) lanes[l] = '1;
    send_state(1600, 1'b1);
    check_lanes("ones");

    do_start();
    send_state(900, 1'b0);
    rd_lane = 5'd3;
    rd_slice = 6'd5;
    #2;
    rst = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'h0);
    chk("arst done", 64'(done), 64'h0);
    chk("arst cnt", 64'(slice_cnt), 64'h0);
    chk("arst slice_out", 64'(slice_out), 64'h0);
    chk("arst lane_out", lane_out, 64'h0);
    m_state = 0;
    m_bit = 0;
    m_slice = 0;
    for (int l = 0; l < 25; l++) mem_lanes[l] = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++)
      send_bit(1'b1, 1'b1);
    check_lanes("post_rst");
    chk("sb empty", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
